mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
//  Parametrised MEM stage and load/store unit for the RV pipeline, between EX/MEM and WB.
//  Drives a req/gnt/rvalid data-memory port and builds byte masks and lane-aligned store data.
//  Sign/zero-extends load data and stalls the pipeline while an access is in flight.
//  Registers rd/rd_op/rd_data into the MEM/WB result.
// PARAMETERS
//  DATA_W  32  datapath width, 32 or 64; 64 enables LD/SD/LWU
//  ADDR_W  32  memory address width
//  REG_W   5   register index width
//  MASK_W  DATA_W/8  byte-enable width (derived, localparam)
// PORTS
//  CLK         in   1        clock, rising edge
//  RST         in   1        reset, asynchronous, active-low
//  rd          in   REG_W    destination register from EX
//  rd_op       in   1        register write enable from EX
//  rd_data     in   DATA_W   ALU result, or store data for stores
//  ld_en       in   1        load request, valid this cycle
//  st_en       in   1        store request, valid this cycle
//  funct3      in   3        RV size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
//  mem_addr    in   ADDR_W   effective address
//  flush       in   1        kill the op presented this cycle
//  stall_o     out  1        hold upstream stages
//  rd_o        out  REG_W    registered to WB
//  rd_op_o     out  1        registered to WB
//  rd_data_o   out  DATA_W   registered to WB
//  mem_req     out  1        memory request
//  mem_we      out  1        1 = store
//  mem_addr_o  out  ADDR_W   address, aligned to DATA_W/8
//  mem_mask    out  MASK_W   byte enables
//  mem_wdata   out  DATA_W   lane-shifted store data
//  mem_gnt     in   1        request accepted
//  mem_rvalid  in   1        response: load data valid, or store ack
//  mem_rdata   in   DATA_W   load data
//  exc_misalign out 1        misaligned access (macro only)
// BEHAVIOUR
//  - Reset (RST=0, async): state IDLE; every output 0, including mem_req, stall_o and rd_op_o.
//  - Non-memory op, no flush: rd_o/rd_op_o/rd_data_o take the inputs at the next edge (1-cycle latency).
//  - FSM IDLE->REQ: on ld_en|st_en without flush, latch op, rd, addr and data. Same edge: rd_op_o=0.
//  - REQ: mem_req=1 with addr/we/mask/wdata held stable until mem_gnt. gnt -> RESP.
//  - RESP: wait for mem_rvalid, then return to IDLE.
//  - RESP, load: extend the selected lane to DATA_W; rd_o=latched rd, rd_op_o=1, rd_data_o=result at the rvalid edge.
//  - RESP, store: rd_op_o=0 at the rvalid edge.
//  - stall_o is combinational: 1 in REQ; 1 in RESP unless mem_rvalid; 1 in IDLE while ld_en|st_en & ~flush.
//  - mem_gnt and mem_rvalid in the same cycle while in REQ: go directly to IDLE, completing as RESP.
//  - Byte lane = addr[log2(MASK_W)-1:0]. Mask: B 1 bit, H 2 bits, W 4 bits, D all bits, shifted by lane.
//  - wdata is the store data shifted left by 8*lane.
//  - Load extension: B/H/W sign-extend, BU/HU/WU zero-extend.
//  - D/WU with DATA_W=32: treated as W, signed.
//  - flush in IDLE: no request; rd_op_o=0 next edge.
//  - flush in REQ before gnt: drop mem_req, go to IDLE; no memory side effect.
//  - flush in RESP: mark the op killed; still wait for rvalid; discard the result (rd_op_o=0).
//  - mem_rvalid in IDLE or REQ without gnt: ignored.
//  - Reset mid-access: FSM returns to IDLE immediately; the outstanding response is ignored.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined:
//    - H with addr[0]!=0, W with addr[1:0]!=0, or D with addr[2:0]!=0 issues no request.
//    - exc_misalign=1 for one cycle (registered); rd_op_o=0; stall_o=0.
//  MEM_MISALIGN_TRAP_EN undefined:
//    - Misaligned low address bits are cleared to the natural alignment and the access proceeds.
//    - exc_misalign is tied to 0.
// TESTING
//  1 Reset: RST=0 mid-REQ -> mem_req=0, stall_o=0, rd_op_o=0 immediately; idle after RST=1.
//  2 ALU pass: rd=5, rd_op=1, rd_data=32'h1234, no ld/st -> next cycle rd_o=5, rd_data_o=32'h1234, stall_o=0.
//  3 LB: addr=32'h1003, rdata=32'h80_00_00_00, gnt after 2 cycles, rvalid 1 later
//    -> mem_mask=4'b1000, rd_data_o=32'hFFFF_FF80, stall_o high 4 cycles.
//  4 SH: addr=32'h2002, rd_data=32'h0000_ABCD -> mem_mask=4'b1100, mem_wdata=32'hABCD_0000, mem_we=1, rd_op_o=0.
//  5 Flush in RESP: LW pending, flush=1, rvalid next cycle with 32'hDEAD_BEEF -> rd_op_o=0, FSM IDLE.
//  6 LW at addr=32'h1001 -> with macro: exc_misalign=1, no mem_req; without: mem_addr_o=32'h1000, normal load.

Source files
------------

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu
// Purpose  : MEM stage / load-store unit between EX/MEM and WB. Issues one
//            access at a time on a req/gnt/rvalid data-memory port, builds
//            byte enables and lane-aligned store data, sign/zero-extends load
//            data, stalls upstream while an access is in flight, and registers
//            the rd/rd_op/rd_data result towards WB.
// Config   : `MEM_MISALIGN_TRAP_EN - when defined, misaligned H/W/D accesses
//            are not issued and raise exc_misalign for one cycle; when
//            undefined, the low address bits are cleared to the natural
//            alignment and the access proceeds.
// Ports    : CLK/RST (async active-low reset)
//            EX side : rd, rd_op, rd_data, ld_en, st_en, funct3, mem_addr, flush
//            Pipeline: stall_o
//            WB side : rd_o, rd_op_o, rd_data_o, exc_misalign
//            Memory  : mem_req, mem_we, mem_addr_o, mem_mask, mem_wdata,
//                      mem_gnt, mem_rvalid, mem_rdata
// Revision : 1.0 - initial release
// ============================================================================
module mem_lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [REG_W-1:0]  rd,
  input  logic              rd_op,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              ld_en,
  input  logic              st_en,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              flush,
  output logic              stall_o,
  output logic [REG_W-1:0]  rd_o,
  output logic              rd_op_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W/8-1:0] mem_mask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              exc_misalign
);

  localparam int MASK_W = DATA_W / 8;
  localparam int LANE_W = $clog2(MASK_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Latched access, held stable for the whole transaction
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [LANE_W-1:0] lane_q;
  logic [REG_W-1:0]  rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [MASK_W-1:0] mask_q;
  logic [DATA_W-1:0] wdata_q;
  logic              killed_q;

  // ---------------------------------------------------------------------------
  // Decode of the op presented in IDLE
  // ---------------------------------------------------------------------------
  logic [1:0]        size_in;
  logic              uns_in;
  logic [3:0]        align_m4;
  logic [LANE_W-1:0] align_m;
  logic [LANE_W-1:0] lane_raw;
  logic [LANE_W-1:0] lane_al;
  logic              misalign_in;
  logic              trap_in;
  logic [MASK_W-1:0] mask_in;
  logic [DATA_W-1:0] wdata_in;
  logic              mem_op;
  logic              start;

  always_comb begin
    size_in = funct3[1:0];
    uns_in  = funct3[2];
    // A 32-bit datapath has no D/WU: both collapse onto a signed word.
    if (DATA_W == 32 && funct3[1]) begin
      size_in = 2'b10;
      uns_in  = 1'b0;
    end

    case (size_in)
      2'b00:   align_m4 = 4'd0;
      2'b01:   align_m4 = 4'd1;
      2'b10:   align_m4 = 4'd3;
      default: align_m4 = 4'd7;
    endcase
    align_m     = align_m4[LANE_W-1:0];
    lane_raw    = mem_addr[LANE_W-1:0];
    misalign_in = |(lane_raw & align_m);
    // Clearing the misaligned bits only matters when the trap is disabled;
    // a trapped access never uses the lane.
    lane_al     = lane_raw & ~align_m;

    for (int i = 0; i < MASK_W; i++) begin
      mask_in[i] = (i >= int'(lane_al)) && (i < int'(lane_al) + (1 << size_in));
    end
    wdata_in = rd_data << {lane_al, 3'b000};
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_in = misalign_in;
`else
  assign trap_in = 1'b0;
`endif

  assign mem_op = (ld_en | st_en) & ~flush;
  assign start  = mem_op & ~trap_in;

  // ---------------------------------------------------------------------------
  // Load data extraction and extension
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ld_ext;
  logic              sgn;
  int                nbits;

  always_comb begin
    shifted = mem_rdata >> {lane_q, 3'b000};
    nbits   = 8 << size_q;
    case (size_q)
      2'b00:   sgn = shifted[7];
      2'b01:   sgn = shifted[15];
      2'b10:   sgn = shifted[31];
      default: sgn = shifted[DATA_W-1];
    endcase
    sgn    = sgn & ~uns_q;
    ld_ext = shifted;
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= nbits) ld_ext[i] = sgn;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  logic complete;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    mem_req   = 1'b0;
    complete  = 1'b0;
    case (state)
      S_IDLE: begin
        stall_o = start;
        if (start) state_nxt = S_REQ;
      end
      S_REQ: begin
        // Request is withdrawn combinationally on flush, so a gnt in that
        // cycle cannot have been an acceptance.
        mem_req = ~flush;
        stall_o = 1'b1;
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (mem_gnt) begin
          if (mem_rvalid) begin
            // Same-cycle response behaves exactly like RESP with rvalid.
            state_nxt = S_IDLE;
            stall_o   = 1'b0;
            complete  = 1'b1;
          end else begin
            state_nxt = S_RESP;
          end
        end
      end
      S_RESP: begin
        stall_o = ~mem_rvalid;
        if (mem_rvalid) begin
          state_nxt = S_IDLE;
          complete  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Access latch and MEM/WB result register
  // ---------------------------------------------------------------------------
  logic kill_now;
  assign kill_now = killed_q | ((state == S_RESP) & flush);

`ifdef MEM_MISALIGN_TRAP_EN
  logic exc_q;
  assign exc_misalign = exc_q;
`else
  assign exc_misalign = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'b00;
      lane_q    <= '0;
      rd_q      <= '0;
      addr_q    <= '0;
      mask_q    <= '0;
      wdata_q   <= '0;
      killed_q  <= 1'b0;
      rd_o      <= '0;
      rd_op_o   <= 1'b0;
      rd_data_o <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      exc_q     <= 1'b0;
`endif
    end else begin
`ifdef MEM_MISALIGN_TRAP_EN
      exc_q <= 1'b0;
`endif
      if (state == S_IDLE) begin
        if (start) begin
          we_q     <= st_en;
          uns_q    <= uns_in;
          size_q   <= size_in;
          lane_q   <= lane_al;
          rd_q     <= rd;
          addr_q   <= {mem_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
          mask_q   <= mask_in;
          wdata_q  <= wdata_in;
          killed_q <= 1'b0;
          rd_op_o  <= 1'b0;
        end else if (mem_op) begin
          // Only reachable when the misalignment trap fires.
          rd_op_o <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
          exc_q   <= 1'b1;
`endif
        end else if (flush) begin
          rd_op_o <= 1'b0;
        end else begin
          rd_o      <= rd;
          rd_op_o   <= rd_op;
          rd_data_o <= rd_data;
        end
      end else begin
        rd_op_o <= 1'b0;
        if (state == S_RESP && flush) killed_q <= 1'b1;
        if (complete && !we_q && !kill_now) begin
          rd_o      <= rd_q;
          rd_op_o   <= 1'b1;
          rd_data_o <= ld_ext;
        end
      end
    end
  end

  assign mem_we     = we_q;
  assign mem_addr_o = addr_q;
  assign mem_mask   = mask_q;
  assign mem_wdata  = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_lsu
// Purpose  : Directed self-checking bench for mem_lsu (DATA_W=32). Expected
//            write-back results are queued when an op is driven and popped
//            whenever the DUT raises rd_op_o.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_lsu;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  rd;
  logic        rd_op;
  logic [31:0] rd_data;
  logic        ld_en, st_en;
  logic [2:0]  funct3;
  logic [31:0] mem_addr;
  logic        flush;
  logic        stall_o;
  logic [4:0]  rd_o;
  logic        rd_op_o;
  logic [31:0] rd_data_o;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_mask;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        exc_misalign;

  mem_lsu #(.DATA_W(32), .ADDR_W(32), .REG_W(5)) dut (
    .CLK(CLK), .RST(RST), .rd(rd), .rd_op(rd_op), .rd_data(rd_data),
    .ld_en(ld_en), .st_en(st_en), .funct3(funct3), .mem_addr(mem_addr),
    .flush(flush), .stall_o(stall_o), .rd_o(rd_o), .rd_op_o(rd_op_o),
    .rd_data_o(rd_data_o), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_o(mem_addr_o), .mem_mask(mem_mask), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .exc_misalign(exc_misalign)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   stall_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    exp_t e;
    e.rd = r;
    e.data = d;
    sbq.push_back(e);
  endtask

  // One clock: sample stall before the edge, then check any write-back.
  task automatic tick();
    exp_t e;
    #1;
    if (stall_o === 1'b1) stall_cnt++;
    @(posedge CLK);
    #1;
    if (rd_op_o === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_wb", {63'd0, rd_op_o}, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("wb_rd", {59'd0, rd_o}, {59'd0, e.rd});
        chk("wb_data", {32'd0, rd_data_o}, {32'd0, e.data});
      end
    end
  endtask

  task automatic idle_inputs();
    rd = '0; rd_op = 1'b0; rd_data = '0; ld_en = 1'b0; st_en = 1'b0;
    funct3 = 3'b000; mem_addr = '0; flush = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  // Load with gnt on the first REQ cycle and rvalid one cycle later.
  task automatic do_load(input string tag, input logic [4:0] r, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] rdata,
                         input logic [31:0] exp_d);
    ld_en = 1'b1; funct3 = f3; mem_addr = a; rd = r; rd_op = 1'b1;
    push(r, exp_d);
    tick();
    ld_en = 1'b0; rd_op = 1'b0;
    chk({tag, "_req"}, {63'd0, mem_req}, 64'd1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] exp_mask,
                          input logic [31:0] exp_wdata);
    st_en = 1'b1; funct3 = f3; mem_addr = a; rd_data = d; rd = 5'd3;
    tick();
    st_en = 1'b0;
    chk({tag, "_mask"}, {60'd0, mem_mask}, {60'd0, exp_mask});
    chk({tag, "_wdata"}, {32'd0, mem_wdata}, {32'd0, exp_wdata});
    chk({tag, "_we"}, {63'd0, mem_we}, 64'd1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk({tag, "_rdop"}, {63'd0, rd_op_o}, 64'd0);
  endtask

  initial begin
    idle_inputs();
    RST = 1'b0;
    #3;
    chk("rst_req", {63'd0, mem_req}, 64'd0);
    chk("rst_stall", {63'd0, stall_o}, 64'd0);
    chk("rst_rdop", {63'd0, rd_op_o}, 64'd0);
    chk("rst_outs", {rd_data_o, mem_wdata}, 64'd0);
    tick();
    RST = 1'b1;
    tick();

    // ALU pass-through
    rd = 5'd5; rd_op = 1'b1; rd_data = 32'h1234;
    push(5'd5, 32'h1234);
    #1 chk("alu_stall", {63'd0, stall_o}, 64'd0);
    tick();
    chk("alu_rdop", {63'd0, rd_op_o}, 64'd1);
    rd_op = 1'b0;
    tick();
    chk("alu_rdop_off", {63'd0, rd_op_o}, 64'd0);

    // LB at lane 3, gnt on the second REQ cycle, rvalid one RESP cycle later
    stall_cnt = 0;
    ld_en = 1'b1; funct3 = 3'b000; mem_addr = 32'h1003; rd = 5'd7; rd_op = 1'b1;
    push(5'd7, 32'hFFFF_FF80);
    tick();
    ld_en = 1'b0; rd_op = 1'b0;
    chk("lb_req", {63'd0, mem_req}, 64'd1);
    chk("lb_mask", {60'd0, mem_mask}, 64'h8);
    chk("lb_addr", {32'd0, mem_addr_o}, 64'h1000);
    chk("lb_we", {63'd0, mem_we}, 64'd0);
    chk("lb_rdop_issue", {63'd0, rd_op_o}, 64'd0);
    tick();
    chk("lb_hold_mask", {60'd0, mem_mask}, 64'h8);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("lb_resp_noreq", {63'd0, mem_req}, 64'd0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h8000_0000;
    tick();
    mem_rvalid = 1'b0;
    chk("lb_rdop", {63'd0, rd_op_o}, 64'd1);
    chk("lb_stall_cycles", 64'(stall_cnt), 64'd4);

    // Sub-word loads: zero/sign extension
    do_load("lh", 5'd12, 3'b001, 32'h1002, 32'h8001_0000, 32'hFFFF_8001);
    do_load("lhu", 5'd13, 3'b101, 32'h1002, 32'h8001_0000, 32'h0000_8001);
    do_load("lbu", 5'd14, 3'b100, 32'h1001, 32'h0000_F000, 32'h0000_00F0);
    do_load("ld32", 5'd15, 3'b011, 32'h1004, 32'h8765_4321, 32'h8765_4321);

    // SH at lane 2, gnt and rvalid in the same REQ cycle
    st_en = 1'b1; funct3 = 3'b001; mem_addr = 32'h2002; rd_data = 32'h0000_ABCD; rd = 5'd9;
    tick();
    st_en = 1'b0;
    chk("sh_mask", {60'd0, mem_mask}, 64'hC);
    chk("sh_wdata", {32'd0, mem_wdata}, 64'hABCD_0000);
    chk("sh_we", {63'd0, mem_we}, 64'd1);
    mem_gnt = 1'b1; mem_rvalid = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk("sh_rdop", {63'd0, rd_op_o}, 64'd0);
    chk("sh_idle", {63'd0, mem_req}, 64'd0);

    do_store("sb", 3'b000, 32'h3001, 32'h0000_00A5, 4'b0010, 32'h0000_A500);
    do_store("sw", 3'b010, 32'h3004, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    // Flush in RESP: response consumed, result discarded
    ld_en = 1'b1; funct3 = 3'b010; mem_addr = 32'h3000; rd = 5'd10;
    tick();
    ld_en = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    chk("flresp_rdop", {63'd0, rd_op_o}, 64'd0);
    rd = 5'd20; rd_op = 1'b1; rd_data = 32'h55AA;
    push(5'd20, 32'h55AA);
    #1 chk("flresp_idle_stall", {63'd0, stall_o}, 64'd0);
    tick();
    rd_op = 1'b0;

    // Flush in REQ before gnt: request dropped at once, back to IDLE
    ld_en = 1'b1; funct3 = 3'b010; mem_addr = 32'h4000; rd = 5'd21;
    tick();
    ld_en = 1'b0; flush = 1'b1;
    #1 chk("flreq_req", {63'd0, mem_req}, 64'd0);
    tick();
    flush = 1'b0;
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("flreq_stray_rvalid", {63'd0, rd_op_o}, 64'd0);

    // Flush in IDLE kills a register write
    rd = 5'd22; rd_op = 1'b1; rd_data = 32'h77; flush = 1'b1;
    tick();
    flush = 1'b0; rd_op = 1'b0;
    chk("flidle_rdop", {63'd0, rd_op_o}, 64'd0);

    // Misaligned LW
    ld_en = 1'b1; funct3 = 3'b010; mem_addr = 32'h1001; rd = 5'd11; rd_op = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
    #1 chk("mis_stall", {63'd0, stall_o}, 64'd0);
    tick();
    ld_en = 1'b0; rd_op = 1'b0;
    chk("mis_noreq", {63'd0, mem_req}, 64'd0);
    chk("mis_exc", {63'd0, exc_misalign}, 64'd1);
    chk("mis_rdop", {63'd0, rd_op_o}, 64'd0);
    tick();
    chk("mis_exc_pulse", {63'd0, exc_misalign}, 64'd0);
`else
    push(5'd11, 32'h1234_5678);
    tick();
    ld_en = 1'b0; rd_op = 1'b0;
    chk("mis_req", {63'd0, mem_req}, 64'd1);
    chk("mis_addr", {32'd0, mem_addr_o}, 64'h1000);
    chk("mis_mask", {60'd0, mem_mask}, 64'hF);
    chk("mis_exc", {63'd0, exc_misalign}, 64'd0);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
`endif

    // Reset mid-REQ
    ld_en = 1'b1; funct3 = 3'b010; mem_addr = 32'h5000; rd = 5'd25;
    tick();
    ld_en = 1'b0;
    chk("mrst_pre_req", {63'd0, mem_req}, 64'd1);
    RST = 1'b0;
    #1;
    chk("mrst_req", {63'd0, mem_req}, 64'd0);
    chk("mrst_stall", {63'd0, stall_o}, 64'd0);
    chk("mrst_rdop", {63'd0, rd_op_o}, 64'd0);
    tick();
    RST = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 1'b0;
    chk("mrst_idle_req", {63'd0, mem_req}, 64'd0);
    chk("mrst_ignored_rvalid", {63'd0, rd_op_o}, 64'd0);

    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
